// File: rtl/quadrature_step_decoder.sv
// Quadrature encoder decoder: synchronise, glitch-filter, decode A/B into a
// wrapping position count, direction, step strobe, step interval and stall.
`timescale 1ns/1ps
module quadrature_step_decoder #(
   parameter int POS_W = 16,
   parameter int INT_W = 16,
   parameter int FILT  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enc_en,
   input  logic             pos_clear,
   input  logic             enc_a,
   input  logic             enc_b,
   output logic [POS_W-1:0] position,
   output logic             dir,
   output logic             step_stb,
   output logic [INT_W-1:0] step_interval,
   output logic             stalled,
   output logic             err
);

   localparam int FW = (FILT > 1) ? $clog2(FILT) : 1;
   localparam logic [FW-1:0] FMAX = FW'(FILT - 1);

   logic [1:0]          s1_q, s2_q;
   logic [1:0]          filt_q, filt_d;
   logic [1:0]          prev_q;
   logic [1:0][FW-1:0]  fcnt_q, fcnt_d;
   logic [POS_W-1:0]    pos_q, pos_d;
   logic                dir_q, dir_d;
   logic                stb_q, stb_d;
   logic [INT_W-1:0]    int_q, int_d;
   logic [INT_W-1:0]    cnt_q, cnt_d;
   logic                stall_q, stall_d;
   logic                err_q, err_d;

   logic [1:0] idx_now, idx_prev, delta;
   logic       fwd, rev, bad, step;

   // Per-channel filter: flip only after FILT consecutive disagreeing samples
   always_comb begin
      filt_d = filt_q;
      fcnt_d = '0;
      for (int c = 0; c < 2; c++) begin
         if (s2_q[c] != filt_q[c]) begin
            if (fcnt_q[c] == FMAX) begin
               filt_d[c] = s2_q[c];
            end else begin
               fcnt_d[c] = fcnt_q[c] + 1'b1;
            end
         end
      end
   end

   // Gray position index {A,B}: 00->0, 10->1, 11->2, 01->3
   assign idx_now  = {filt_q[0], filt_q[1] ^ filt_q[0]};
   assign idx_prev = {prev_q[0], prev_q[1] ^ prev_q[0]};
   assign delta    = idx_now - idx_prev;

   always_comb begin
      fwd = 1'b0;
      rev = 1'b0;
      bad = 1'b0;
      if (enc_en) begin
         unique case (delta)
            2'd1:    fwd = 1'b1;
            2'd3:    rev = 1'b1;
            2'd2:    bad = 1'b1;
            default: ;
         endcase
      end
   end

   assign step = fwd | rev;

   always_comb begin
      pos_d = pos_q;
      dir_d = dir_q;
      err_d = err_q;
      int_d = int_q;
      cnt_d = cnt_q;
      stb_d = step;
      if (fwd) begin
         pos_d = pos_q + 1'b1;
         dir_d = 1'b0;
      end
      if (rev) begin
         pos_d = pos_q - 1'b1;
         dir_d = 1'b1;
      end
      if (bad) begin
         err_d = 1'b1;
      end
      if (step) begin
         int_d = cnt_q;
      end
      if (!enc_en) begin
         cnt_d = '1;
      end else if (step || pos_clear) begin
         cnt_d = INT_W'(1);
      end else if (cnt_q != '1) begin
         cnt_d = cnt_q + 1'b1;
      end
      // Clear beats a coincident step on the count, not on strobe/dir
      if (pos_clear) begin
         pos_d = '0;
         err_d = 1'b0;
      end
      stall_d = enc_en && (cnt_d == '1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q    <= '0;
         s2_q    <= '0;
         filt_q  <= '0;
         fcnt_q  <= '0;
         prev_q  <= '0;
         pos_q   <= '0;
         dir_q   <= 1'b0;
         stb_q   <= 1'b0;
         int_q   <= '0;
         cnt_q   <= '1;
         stall_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         s1_q    <= {enc_a, enc_b};
         s2_q    <= s1_q;
         filt_q  <= filt_d;
         fcnt_q  <= fcnt_d;
         prev_q  <= filt_q;
         pos_q   <= pos_d;
         dir_q   <= dir_d;
         stb_q   <= stb_d;
         int_q   <= int_d;
         cnt_q   <= cnt_d;
         stall_q <= stall_d;
         err_q   <= err_d;
      end
   end

   assign position      = pos_q;
   assign dir           = dir_q;
   assign step_stb      = stb_q;
   assign step_interval = int_q;
   assign stalled       = stall_q;
   assign err           = err_q;

endmodule

// File: tb/tb_quadrature_step_decoder.sv
// Bench for quadrature_step_decoder: cycle model compared every clock plus
// directed literal checks of latency, wrap, filtering, error, stall and reset.
`timescale 1ns/1ps
module tb_quadrature_step_decoder;

   localparam int FILT = 4;
   localparam int SAT  = 65535;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        enc_en = 1'b0;
   logic        pos_clear = 1'b0;
   logic        enc_a = 1'b0;
   logic        enc_b = 1'b0;
   logic [15:0] position;
   logic        dir;
   logic        step_stb;
   logic [15:0] step_interval;
   logic        stalled;
   logic        err;

   int checks = 0;
   int errors = 0;
   int stb_cnt = 0;
   bit chk_en = 1'b0;

   quadrature_step_decoder #(.POS_W(16), .INT_W(16), .FILT(FILT)) dut (
      .clk(clk), .rst_n(rst_n), .enc_en(enc_en), .pos_clear(pos_clear),
      .enc_a(enc_a), .enc_b(enc_b), .position(position), .dir(dir),
      .step_stb(step_stb), .step_interval(step_interval),
      .stalled(stalled), .err(err)
   );

   always #5 clk = ~clk;

   // Model: quadrature phase number of each {A,B} code (index = A*2+B)
   int G [4] = '{0, 3, 1, 2};

   logic [1:0] m_s1, m_s2, m_filt, m_prev;
   logic [1:0] hist [FILT-1];
   int  m_pos, m_int, m_cnt;
   bit  m_dir, m_stb, m_stall, m_err;
   logic [1:0] t_filt;
   int  t_d, t_cnt;
   bit  t_all, t_step;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_s1 <= '0; m_s2 <= '0; m_filt <= '0; m_prev <= '0;
         for (int i = 0; i < FILT-1; i++) hist[i] <= '0;
         m_pos <= 0; m_int <= 0; m_cnt <= SAT;
         m_dir <= 0; m_stb <= 0; m_stall <= 0; m_err <= 0;
      end else begin
         for (int c = 0; c < 2; c++) begin
            t_all = (m_s2[c] != m_filt[c]);
            for (int i = 0; i < FILT-1; i++)
               if (hist[i][c] == m_filt[c]) t_all = 0;
            t_filt[c] = t_all ? m_s2[c] : m_filt[c];
         end
         t_d = (G[m_filt] - G[m_prev] + 4) % 4;
         t_step = enc_en && (t_d == 1 || t_d == 3);
         if (!enc_en) t_cnt = SAT;
         else if (t_step || pos_clear) t_cnt = 1;
         else t_cnt = (m_cnt + 1 > SAT) ? SAT : m_cnt + 1;
         m_s1 <= {enc_a, enc_b};
         m_s2 <= m_s1;
         hist[0] <= m_s2;
         for (int i = 1; i < FILT-1; i++) hist[i] <= hist[i-1];
         m_filt <= t_filt;
         m_prev <= m_filt;
         m_stb <= t_step;
         if (t_step) begin
            m_dir <= (t_d == 3);
            m_int <= m_cnt;
         end
         if (pos_clear) m_pos <= 0;
         else if (t_step) m_pos <= (t_d == 1) ? (m_pos + 1) % 65536
                                               : (m_pos + 65535) % 65536;
         if (pos_clear) m_err <= 0;
         else if (enc_en && t_d == 2) m_err <= 1;
         m_cnt <= t_cnt;
         m_stall <= enc_en && (t_cnt == SAT);
      end
   end

   task automatic check(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("m_position", position, m_pos);
         check("m_dir", dir, m_dir);
         check("m_step_stb", step_stb, m_stb);
         check("m_interval", step_interval, m_int);
         check("m_stalled", stalled, m_stall);
         check("m_err", err, m_err);
      end
      if (step_stb) stb_cnt <= stb_cnt + 1;
   end

   task automatic setp(input logic a, input logic b);
      @(negedge clk);
      enc_a = a;
      enc_b = b;
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      pos_clear = 1'b1;
      @(negedge clk);
      pos_clear = 1'b0;
   endtask

   task automatic wait_stb(input int maxc, output int n);
      bit found;
      found = 0;
      n = 0;
      while (!found && n < maxc) begin
         @(posedge clk);
         #1;
         n++;
         if (step_stb) found = 1;
      end
      check("stb_timeout", found, 1);
   endtask

   logic [1:0] fseq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
   int lat, s0;

   initial begin
      #1 rst_n = 1'b0;
      #1 chk_en = 1'b1;
      clks(3);
      check("reset_pos", position, 0);
      check("reset_int", step_interval, 0);
      @(negedge clk) rst_n = 1'b1;
      enc_en = 1'b1;
      clks(5);

      // forward 8 edges, 20 clocks apart
      for (int i = 0; i < 8; i++) begin
         setp(fseq[i%4][1], fseq[i%4][0]);
         if (i == 0) begin
            wait_stb(20, lat);
            check("latency", lat, 7);
            check("first_interval", step_interval, 16'hFFFF);
            clks(13);
         end else begin
            clks(19);
         end
      end
      clks(20);
      check("fwd_steps", stb_cnt, 8);
      check("fwd_pos", position, 8);
      check("fwd_dir", dir, 0);
      check("fwd_interval", step_interval, 20);

      // reverse through zero, then back
      pulse_clear();
      setp(0, 1); clks(11);
      setp(1, 1); clks(11);
      setp(1, 0); clks(11);
      check("rev_pos", position, 16'hFFFD);
      check("rev_dir", dir, 1);
      setp(1, 1); clks(11);
      setp(0, 1); clks(11);
      setp(0, 0); clks(11);
      check("ret_pos", position, 0);
      check("ret_dir", dir, 0);

      // glitch filter: 3-clock pulse rejected, 4-clock pulse accepted
      s0 = stb_cnt;
      setp(1, 0); clks(2); setp(0, 0); clks(15);
      check("glitch3_steps", stb_cnt, s0);
      check("glitch3_pos", position, 0);
      setp(1, 0); clks(3); setp(0, 0); clks(15);
      check("glitch4_steps", stb_cnt, s0 + 2);
      check("glitch4_pos", position, 0);
      check("glitch4_dir", dir, 1);

      // both channels at once
      setp(1, 1); clks(15);
      check("illegal_err", err, 1);
      check("illegal_pos", position, 0);
      pulse_clear(); clks(2);
      check("clear_err", err, 0);
      check("clear_pos", position, 0);
      setp(0, 1); clks(11);
      setp(0, 0); clks(11);
      check("after_err_pos", position, 2);

      // stall then recovery
      pulse_clear();
      clks(65540);
      check("stalled_set", stalled, 1);
      setp(1, 0);
      wait_stb(20, lat);
      check("stall_interval", step_interval, 16'hFFFF);
      check("stall_clear", stalled, 0);
      clks(3);

      // asynchronous reset mid-run
      setp(1, 1); clks(25);
      setp(0, 1); clks(4);
      #2 rst_n = 1'b0;
      #1;
      check("arst_pos", position, 0);
      check("arst_int", step_interval, 0);
      check("arst_dir", dir, 0);
      check("arst_stb", step_stb, 0);
      check("arst_err", err, 0);
      enc_a = 1'b0;
      enc_b = 1'b0;
      clks(3);
      rst_n = 1'b1;
      clks(20);
      check("post_rst_pos", position, 0);

      // disable, jump inputs to 11, re-enable: no step, no error
      enc_en = 1'b0;
      setp(1, 1); clks(20);
      enc_en = 1'b1;
      s0 = stb_cnt;
      clks(20);
      check("reen_steps", stb_cnt, s0);
      check("reen_err", err, 0);
      check("reen_pos", position, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "timeout");
   end

endmodule
